mem_arbiter: RTL and testbench

Shares one single-port synchronous 16-bit program/data RAM between two requesters: the accumulator processor (CPU port) and a host loader/debug port (HOST port). It arbitrates, launches one RAM access at a time, and returns read data with a valid pulse. It sits between the processor's memory interface and the RAM macro. It replaces the direct processor-to-RAM wiring, so the host can load programs and inspect memory.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_rr_arb2.sv | 23 ++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the CPU/HOST single-port RAM arbiter.
package mem_arb_pkg;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 16;

    localparam int PORT_CPU  = 0;
    localparam int PORT_HOST = 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RWAIT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACCESS = ST_ACCESS,
        RWAIT  = ST_RWAIT
    } state_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the port not granted last.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[PORT_CPU] && req[PORT_HOST]) begin
            // last_grant holds the index of the previous winner
            if (last_grant) gnt[PORT_CPU] = 1'b1;
            else            gnt[PORT_HOST] = 1'b1;
        end else if (req[PORT_CPU]) begin
            gnt[PORT_CPU] = 1'b1;
        end else if (req[PORT_HOST]) begin
            gnt[PORT_HOST] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port synchronous RAM between the processor (CPU) and a host loader (HOST).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

    state_t     state;
    logic       last_grant;
    logic       owner;
    logic [1:0] cnt;
    logic [1:0] req_vec;
    logic [1:0] pick;

    assign req_vec = {host_req, cpu_req && !host_lock};

    rr_arb2 u_rr_arb2 (
        .req        (req_vec),
        .last_grant (last_grant),
        .gnt        (pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            cnt         <= 2'd0;
            cpu_gnt     <= 1'b0;
            cpu_rvalid  <= 1'b0;
            cpu_rdata   <= '0;
            host_gnt    <= 1'b0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            busy        <= 1'b0;
        end else begin
            cpu_gnt     <= 1'b0;
            host_gnt    <= 1'b0;
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            case (state)
                IDLE: begin
                    if (|pick) begin
                        owner      <= pick[PORT_HOST];
                        last_grant <= pick[PORT_HOST];
                        ram_en     <= 1'b1;
                        if (pick[PORT_HOST]) begin
                            ram_we    <= host_we;
                            ram_addr  <= host_addr;
                            ram_wdata <= host_wdata;
                            host_gnt  <= 1'b1;
                        end else begin
                            ram_we    <= cpu_we;
                            ram_addr  <= cpu_addr;
                            ram_wdata <= cpu_wdata;
                            cpu_gnt   <= 1'b1;
                        end
                        state <= ACCESS;
                        busy  <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (ram_we) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= LAT_M1;
                        state <= RWAIT;
                    end
                end
                RWAIT: begin
                    // Counter reaches zero in the cycle the RAM presents valid read data
                    if (cnt == 2'd0) begin
                        if (owner) begin
                            host_rdata  <= ram_rdata;
                            host_rvalid <= 1'b1;
                        end else begin
                            cpu_rdata  <= ram_rdata;
                            cpu_rvalid <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with RD_LAT=1, one with RD_LAT=3, each with a RAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0, host_lock = 0;
    logic [11:0] cpu_addr = 0, host_addr = 0;
    logic [15:0] cpu_wdata = 0, host_wdata = 0;
    logic        cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, ram_en, ram_we, busy;
    logic [15:0] cpu_rdata, host_rdata, ram_wdata, ram_rdata;
    logic [11:0] ram_addr;

    logic        b_cpu_req = 0, b_cpu_we = 0, b_host_req = 0, b_host_we = 0;
    logic [11:0] b_cpu_addr = 0, b_host_addr = 0;
    logic        b_cpu_gnt, b_cpu_rvalid, b_host_gnt, b_host_rvalid, b_ram_en, b_ram_we, b_busy;
    logic [15:0] b_cpu_rdata, b_host_rdata, b_ram_wdata, b_ram_rdata;
    logic [11:0] b_ram_addr;

    logic [15:0] mem1 [0:4095];
    logic [15:0] mem3 [0:4095];
    logic [15:0] p1;
    logic [15:0] p3 [0:2];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(12), .DW(16), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_lock(host_lock),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    mem_arbiter #(.AW(12), .DW(16), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(16'h0000),
        .cpu_gnt(b_cpu_gnt), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
        .host_req(b_host_req), .host_we(b_host_we), .host_addr(b_host_addr), .host_wdata(16'h0000),
        .host_lock(1'b0),
        .host_gnt(b_host_gnt), .host_rvalid(b_host_rvalid), .host_rdata(b_host_rdata),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata), .busy(b_busy)
    );

    // RAM models: data appears exactly RD_LAT cycles after the ram_en cycle
    always @(posedge clk) begin
        if (ram_en && ram_we) mem1[ram_addr] <= ram_wdata;
        p1 <= (ram_en && !ram_we) ? mem1[ram_addr] : 16'hDEAD;
        if (b_ram_en && b_ram_we) mem3[b_ram_addr] <= b_ram_wdata;
        p3[0] <= (b_ram_en && !b_ram_we) ? mem3[b_ram_addr] : 16'hDEAD;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign ram_rdata   = p1;
    assign b_ram_rdata = p3[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [15:0] d);
        cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_wdata = d;
        tick();
        chk("wr_gnt", {31'd0, cpu_gnt}, 1);
        chk("wr_ram_addr", {20'd0, ram_addr}, {20'd0, a});
        chk("wr_ram_wdata", {16'd0, ram_wdata}, {16'd0, d});
        cpu_req = 0; cpu_we = 0;
        tick();
    endtask

    task automatic cpu_read(input logic [11:0] a, input logic [15:0] exp);
        cpu_req = 1; cpu_we = 0; cpu_addr = a;
        tick();
        chk("rd_gnt", {31'd0, cpu_gnt}, 1);
        chk("rd_ram_addr", {20'd0, ram_addr}, {20'd0, a});
        cpu_req = 0;
        tick();
        tick();
        chk("rd_rvalid", {31'd0, cpu_rvalid}, 1);
        chk("rd_rdata", {16'd0, cpu_rdata}, {16'd0, exp});
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem1[i] = 16'h0000;
            mem3[i] = 16'h0000;
        end
        mem1[12'h005] = 16'h1234;
        mem1[12'h000] = 16'h5A5A;
        mem3[12'h800] = 16'hC0DE;
        mem3[12'h005] = 16'h0777;

        // Reset state
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_ram_en", {31'd0, ram_en}, 0);
        chk("rst_cpu_rdata", {16'd0, cpu_rdata}, 0);
        chk("rst_host_gnt", {31'd0, host_gnt}, 0);
        chk("rst_b_busy", {31'd0, b_busy}, 0);
        rst_n = 1;
        tick();

        // CPU read of 0x005 with RD_LAT=1
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h005;
        tick();
        chk("r1_cpu_gnt", {31'd0, cpu_gnt}, 1);
        chk("r1_ram_en", {31'd0, ram_en}, 1);
        chk("r1_ram_we", {31'd0, ram_we}, 0);
        chk("r1_ram_addr", {20'd0, ram_addr}, 32'h005);
        chk("r1_host_gnt", {31'd0, host_gnt}, 0);
        cpu_req = 0;
        tick();
        chk("r1_t2_gnt", {31'd0, cpu_gnt}, 0);
        chk("r1_t2_ram_en", {31'd0, ram_en}, 0);
        chk("r1_t2_rvalid", {31'd0, cpu_rvalid}, 0);
        chk("r1_t2_busy", {31'd0, busy}, 1);
        tick();
        chk("r1_rvalid", {31'd0, cpu_rvalid}, 1);
        chk("r1_rdata", {16'd0, cpu_rdata}, 32'h1234);
        chk("r1_host_rvalid", {31'd0, host_rvalid}, 0);
        chk("r1_host_rdata", {16'd0, host_rdata}, 0);
        chk("r1_busy_idle", {31'd0, busy}, 0);
        tick();
        chk("r1_rvalid_pulse", {31'd0, cpu_rvalid}, 0);
        chk("r1_rdata_hold", {16'd0, cpu_rdata}, 32'h1234);

        // Round robin from reset: both request writes continuously
        rst_n = 0; tick(); rst_n = 1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h010; cpu_wdata = 16'hAAAA;
        host_req = 1; host_we = 1; host_addr = 12'h011; host_wdata = 16'h5555;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("rr_cpu_gnt", {31'd0, cpu_gnt}, {31'd0, (i % 4) == 1});
            chk("rr_host_gnt", {31'd0, host_gnt}, {31'd0, (i % 4) == 3});
            if (i == 3) chk("rr_host_addr", {20'd0, ram_addr}, 32'h011);
        end
        cpu_req = 0; host_req = 0; cpu_we = 0; host_we = 0;
        tick();
        chk("rr_mem_cpu", {16'd0, mem1[12'h010]}, 32'hAAAA);
        chk("rr_mem_host", {16'd0, mem1[12'h011]}, 32'h5555);

        // host_lock: host writes then reads 0xFFF while CPU is held off
        host_lock = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 12'h020;
        host_req = 1; host_we = 1; host_addr = 12'hFFF; host_wdata = 16'hBEEF;
        tick();
        chk("lk_host_gnt_w", {31'd0, host_gnt}, 1);
        chk("lk_cpu_gnt_1", {31'd0, cpu_gnt}, 0);
        chk("lk_ram_we", {31'd0, ram_we}, 1);
        chk("lk_ram_wdata", {16'd0, ram_wdata}, 32'hBEEF);
        host_we = 0;
        tick();
        chk("lk_cpu_gnt_2", {31'd0, cpu_gnt}, 0);
        tick();
        chk("lk_host_gnt_r", {31'd0, host_gnt}, 1);
        chk("lk_cpu_gnt_3", {31'd0, cpu_gnt}, 0);
        host_req = 0;
        tick();
        chk("lk_cpu_gnt_4", {31'd0, cpu_gnt}, 0);
        tick();
        chk("lk_host_rvalid", {31'd0, host_rvalid}, 1);
        chk("lk_host_rdata", {16'd0, host_rdata}, 32'hBEEF);
        chk("lk_cpu_gnt_5", {31'd0, cpu_gnt}, 0);
        tick();
        chk("lk_cpu_gnt_6", {31'd0, cpu_gnt}, 0);
        chk("lk_ram_idle", {31'd0, ram_en}, 0);
        host_lock = 0;
        tick();
        chk("lk_cpu_gnt_after", {31'd0, cpu_gnt}, 1);
        cpu_req = 0;
        tick(); tick();
        chk("lk_cpu_rvalid", {31'd0, cpu_rvalid}, 1);

        // RD_LAT=3 host read with a CPU request arriving during the access
        b_host_req = 1; b_host_we = 0; b_host_addr = 12'h800;
        tick();
        chk("l3_host_gnt", {31'd0, b_host_gnt}, 1);
        b_host_req = 0;
        tick();
        b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 12'h005;
        chk("l3_busy", {31'd0, b_busy}, 1);
        tick();
        chk("l3_cpu_gnt_t3", {31'd0, b_cpu_gnt}, 0);
        chk("l3_rvalid_t3", {31'd0, b_host_rvalid}, 0);
        tick();
        chk("l3_cpu_gnt_t4", {31'd0, b_cpu_gnt}, 0);
        chk("l3_rvalid_t4", {31'd0, b_host_rvalid}, 0);
        tick();
        chk("l3_host_rvalid", {31'd0, b_host_rvalid}, 1);
        chk("l3_host_rdata", {16'd0, b_host_rdata}, 32'hC0DE);
        chk("l3_cpu_gnt_t5", {31'd0, b_cpu_gnt}, 0);
        tick();
        chk("l3_cpu_gnt_t6", {31'd0, b_cpu_gnt}, 1);
        b_cpu_req = 0;
        tick(); tick(); tick();
        chk("l3_cpu_rvalid_early", {31'd0, b_cpu_rvalid}, 0);
        tick();
        chk("l3_cpu_rvalid", {31'd0, b_cpu_rvalid}, 1);
        chk("l3_cpu_rdata", {16'd0, b_cpu_rdata}, 32'h0777);

        // Reset asserted during RWAIT of a CPU read
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h005;
        tick();
        chk("rw_gnt", {31'd0, cpu_gnt}, 1);
        cpu_req = 0;
        tick();
        chk("rw_busy", {31'd0, busy}, 1);
        rst_n = 0;
        #1;
        chk("rw_rst_busy", {31'd0, busy}, 0);
        chk("rw_rst_ram_addr", {20'd0, ram_addr}, 0);
        chk("rw_rst_cpu_rdata", {16'd0, cpu_rdata}, 0);
        tick();
        rst_n = 1;
        tick();
        chk("rw_no_rvalid_1", {31'd0, cpu_rvalid}, 0);
        tick();
        chk("rw_no_rvalid_2", {31'd0, cpu_rvalid}, 0);
        chk("rw_rdata_still_0", {16'd0, cpu_rdata}, 0);
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h030; cpu_wdata = 16'h0001;
        host_req = 1; host_we = 1; host_addr = 12'h031; host_wdata = 16'h0002;
        tick();
        chk("rw_tie_cpu", {31'd0, cpu_gnt}, 1);
        chk("rw_tie_host", {31'd0, host_gnt}, 0);
        cpu_req = 0;
        tick();
        tick();
        chk("rw_host_next", {31'd0, host_gnt}, 1);
        host_req = 0; cpu_we = 0; host_we = 0;
        tick();

        // Address wrap corners
        cpu_write(12'hFFF, 16'hFFFF);
        cpu_write(12'h000, 16'h0000);
        cpu_read(12'hFFF, 16'hFFFF);
        cpu_read(12'h000, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
